// File: rtl/smc_pwm_capture_if.sv
// Q register bus bundle for the PWM capture unit.
//   QWRITE   1 = write, 0 = read (qualified by QSEL)
//   QSEL     block select
//   QADDR    byte register address
//   QDATAIN  write data
//   QDATAOUT read data (combinational from the slave)
interface smc_pwm_capture_if;
  logic        QWRITE;
  logic        QSEL;
  logic [6:0]  QADDR;
  logic [15:0] QDATAIN;
  logic [15:0] QDATAOUT;

  modport master (output QWRITE, QSEL, QADDR, QDATAIN, input QDATAOUT);
  modport slave  (input QWRITE, QSEL, QADDR, QDATAIN, output QDATAOUT);
endinterface

// File: rtl/smc_pwm_capture.sv
// PWM capture unit: samples one selected MNM/MNP coil line and measures
// its period and high time in QCLK cycles. Results are read over the Q bus.
//   QCLK     bus and capture clock
//   QRESET   asynchronous active-low reset
//   qbus     Q register bus (slave side)
//   MNM/MNP  12 coil minus / plus PWM lines each
//   CAP_IRQ  STATUS.VALID & CTL.IE
// Registers: 0x00 CTL {IE,CHSEL[4:0],EN}, 0x02 PERIOD, 0x04 HIGH,
//            0x06 STATUS {LEVEL,TMO,OVR,VALID} (TMO/OVR/VALID write-1-to-clear).
// Optional: define SMC_CAP_FILT_EN to insert a FILT_LEN-cycle deglitch
// filter after the channel mux.
module smc_pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic             QCLK,
  input  logic             QRESET,
  smc_pwm_capture_if.slave qbus,
  input  logic [11:0]      MNM,
  input  logic [11:0]      MNP,
  output logic             CAP_IRQ
);
  localparam int NLINE = 24;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;

  logic [SYNC_STAGES-1:0][NLINE-1:0] sync_q;
  logic             en_q, ie_q;
  logic [4:0]       chsel_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, hi_q, hi_d, period_q, high_q;
  logic             valid_q, ovr_q, tmo_q;
  logic             raw, lvl, lvl_d, edge_blk_q, rise, fall;
  logic             wr, ctl_wr, stat_wr, abort, cap, tmo;
  state_t           state_q, state_d;
  logic [15:0]      period_ext, high_ext;
  logic [8:0]       unused_wdata;

  assign unused_wdata = qbus.QDATAIN[15:7];

  // Bus write decode. A CTL write with an out-of-range CHSEL is dropped whole.
  assign wr      = qbus.QSEL & qbus.QWRITE;
  assign ctl_wr  = wr && (qbus.QADDR == 7'h00) && (qbus.QDATAIN[5:1] < 5'd24);
  assign stat_wr = wr && (qbus.QADDR == 7'h06);
  assign abort   = ctl_wr && ((qbus.QDATAIN[5:1] != chsel_q) || (qbus.QDATAIN[0] != en_q));

  // Synchronizers on all 24 lines; line n<12 is MNM[n], else MNP[n-12].
  always_ff @(posedge QCLK or negedge QRESET) begin
    if (!QRESET) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= {MNP, MNM};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign raw = sync_q[SYNC_STAGES-1][chsel_q];

`ifdef SMC_CAP_FILT_EN
  localparam int FW = $clog2(FILT_LEN + 1);
  logic          filt_q;
  logic [FW-1:0] fcnt_q;

  // Filtered level follows raw only after FILT_LEN consecutive differing
  // cycles. Reloaded from the new channel right after a CTL change.
  always_ff @(posedge QCLK or negedge QRESET) begin
    if (!QRESET) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else if (edge_blk_q) begin
      filt_q <= raw;
      fcnt_q <= '0;
    end else if (raw != filt_q) begin
      if (fcnt_q == FW'(FILT_LEN - 1)) begin
        filt_q <= raw;
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end else begin
      fcnt_q <= '0;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = raw;
`endif

  // The cycle after a CTL change the delayed copy still holds the old
  // channel, so edges are masked and the copy is reseeded from the new one.
  assign rise = lvl & ~lvl_d & ~edge_blk_q;
  assign fall = ~lvl & lvl_d & ~edge_blk_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    cap     = 1'b0;
    tmo     = 1'b0;
    if (abort) begin
      state_d = qbus.QDATAIN[0] ? WAIT_RISE : IDLE;
      cnt_d   = '0;
      hi_d    = '0;
    end else begin
      case (state_q)
        IDLE: cnt_d = '0;
        WAIT_RISE: if (rise) begin
          state_d = MEAS_HIGH;
          cnt_d   = CNT_W'(1);
        end
        MEAS_HIGH: begin
          if (cnt_q == CNT_MAX) begin
            tmo     = 1'b1;
            state_d = WAIT_RISE;
            cnt_d   = '0;
          end else if (fall) begin
            hi_d    = cnt_q;
            cnt_d   = cnt_q + 1'b1;
            state_d = MEAS_LOW;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        MEAS_LOW: begin
          if (rise) begin
            cap     = 1'b1;
            cnt_d   = CNT_W'(1);
            state_d = MEAS_HIGH;
          end else if (cnt_q == CNT_MAX) begin
            tmo     = 1'b1;
            state_d = WAIT_RISE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge QCLK or negedge QRESET) begin
    if (!QRESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      period_q   <= '0;
      high_q     <= '0;
      en_q       <= 1'b0;
      ie_q       <= 1'b0;
      chsel_q    <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
      tmo_q      <= 1'b0;
      lvl_d      <= 1'b0;
      edge_blk_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      edge_blk_q <= abort;
      lvl_d      <= edge_blk_q ? raw : lvl;
      if (cap) begin
        period_q <= cnt_q;
        high_q   <= hi_q;
      end
      if (ctl_wr) begin
        en_q    <= qbus.QDATAIN[0];
        chsel_q <= qbus.QDATAIN[5:1];
        ie_q    <= qbus.QDATAIN[6];
      end
      // Hardware set wins over a same-cycle write-1-to-clear.
      valid_q <= cap | (valid_q & ~(stat_wr & qbus.QDATAIN[0]));
      ovr_q   <= (cap & valid_q) | (ovr_q & ~(stat_wr & qbus.QDATAIN[1]));
      tmo_q   <= tmo | (tmo_q & ~(stat_wr & qbus.QDATAIN[2]));
    end
  end

  assign period_ext = 16'(period_q);
  assign high_ext   = 16'(high_q);

  always_comb begin
    qbus.QDATAOUT = 16'h0000;
    if (qbus.QSEL && !qbus.QWRITE) begin
      case (qbus.QADDR)
        7'h00:   qbus.QDATAOUT = {9'h0, ie_q, chsel_q, en_q};
        7'h02:   qbus.QDATAOUT = period_ext;
        7'h04:   qbus.QDATAOUT = high_ext;
        7'h06:   qbus.QDATAOUT = {12'h0, raw, tmo_q, ovr_q, valid_q};
        default: qbus.QDATAOUT = 16'h0000;
      endcase
    end
  end

  assign CAP_IRQ = valid_q & ie_q;
endmodule

// File: doc/smc_pwm_capture.md
Name: smc_pwm_capture

Overview:
- Receive-side counterpart of the stepper motor controller PWM outputs: a capture unit that samples one selected MNM/MNP coil line and measures its PWM period and high time in QCLK cycles.
- Results are read over the same Q register bus the controller uses, so motor-drive duty can be checked in loopback and in system.
- Sits beside the controller, with its MNM/MNP inputs tied to the controller outputs.

Parameters:
- CNT_W, 16: width of the period/high counters and result registers (max 16).
- SYNC_STAGES, 2: flip-flop synchronizer depth on every MNM/MNP input.
- FILT_LEN, 3: stable-cycle count for the glitch filter (used only with SMC_CAP_FILT_EN).

Ports:
- QCLK  in  1  bus and capture clock.
- QRESET  in  1  asynchronous, active-low reset.
- QWRITE  in  1  1 = write, 0 = read; qualified by QSEL.
- QSEL  in  1  block select.
- QADDR  in  7  byte register address.
- QDATAIN  in  16  write data.
- QDATAOUT  out  16  read data.
- MNM  in  12  coil minus PWM lines.
- MNP  in  12  coil plus PWM lines.
- CAP_IRQ  out  1  high while STATUS.VALID=1 and CTL.IE=1.

Behaviour:
- **Register map:**
  - 0x00 CTL, read/write:
    - bit0 EN.
    - bits5:1 CHSEL: 0–11 selects MNM[n], 12–23 selects MNP[n-12].
    - bit6 IE.
    - Other bits read 0.
    - A write with CHSEL≥24 is ignored entirely; CTL is unchanged.
  - 0x02 PERIOD, read-only.
  - 0x04 HIGH, read-only.
  - 0x06 STATUS:
    - bit0 VALID, bit1 OVR, bit2 TMO: write-1-to-clear.
    - bit3 LEVEL: read-only, current synchronized level of the selected line.
  - Unmapped addresses read 0; writes to them are ignored.
- **Bus timing:**
  - Write takes effect on the QCLK edge where QSEL=1 and QWRITE=1.
  - QDATAOUT is combinational from QADDR when QSEL=1 and QWRITE=0; otherwise 16'h0000.
- **Input path:**
  - All 24 lines pass through SYNC_STAGES flops, then the CHSEL mux.
  - Rise/fall detect compares the muxed value with a 1-cycle delayed copy.
  - Input-to-edge-detect latency is SYNC_STAGES+1 cycles.
- **State machine** (cnt and hi are CNT_W wide):
  - IDLE: entered when EN=0.
  - EN 0→1 → WAIT_RISE. Any partial pulse is discarded.
  - WAIT_RISE: on rise → MEAS_HIGH, cnt=1.
  - MEAS_HIGH: cnt+=1 each cycle. On fall → hi=cnt, then MEAS_LOW.
  - MEAS_LOW: cnt+=1 each cycle. On rise:
    - PERIOD=cnt and HIGH=hi, loaded in the same cycle so the pair is always coherent.
    - If VALID was already 1, set OVR.
    - Set VALID.
    - cnt=1; stay in MEAS_HIGH for back-to-back capture.
  - Timeout: in MEAS_HIGH or MEAS_LOW, if cnt reaches all-ones with no completing edge:
    - Set TMO and go to WAIT_RISE.
    - PERIOD/HIGH are unchanged.
    - This covers 0% and 100% duty.
- **Boundary and ordering rules:**
  - A CTL write that changes CHSEL, or EN 1→0, aborts any measurement:
    - Counters clear.
    - State goes to WAIT_RISE (CHSEL change with EN=1) or IDLE (EN→0).
    - PERIOD, HIGH and STATUS are kept.
  - Same-cycle write-1-to-clear and hardware set of a STATUS bit: the set wins.
- **Reset (QRESET=0):**
  - CTL, PERIOD, HIGH, STATUS, counters and synchronizers all return to 0.
  - State returns to IDLE.
  - QDATAOUT=0 and CAP_IRQ=0.
  - Reset asserted mid-measurement discards it immediately.

Optional Feature:
- SMC_CAP_FILT_EN defined:
  - Each muxed, synchronized level passes a deglitch filter.
  - The filtered level changes only after the raw level has differed from it for FILT_LEN consecutive cycles.
  - Edge-detect latency grows by FILT_LEN cycles.
  - Pulses shorter than FILT_LEN cycles are invisible to the capture logic.
  - The filter is cleared on CHSEL change.
- SMC_CAP_FILT_EN undefined: no filter, and FILT_LEN is unused.

Test Plan:
1. Drive MNP[4] with the pattern 1,1,1,0 repeating, then write CTL=0x0021 (EN=1, CHSEL=16) → after the second full rise, PERIOD=4, HIGH=3, VALID=1, LEVEL toggles.
2. In scenario 1, leave VALID uncleared for 2 further periods → OVR=1. Write STATUS=0x0003 → VALID=0 and OVR=0 at the next capture boundary, then VALID=1 again.
3. Hold MNM[1]=0 after one rise, with CTL=0x0003 (EN, CHSEL=1) → TMO=1 after 65535 cycles in MEAS_LOW, PERIOD/HIGH unchanged, state is WAIT_RISE.
4. Write CTL with CHSEL=25 → CTL readback unchanged. Then change CHSEL from 16 to 5 mid-pulse → no capture is produced from the partial pulse.
5. Pulse QRESET low during MEAS_LOW → all registers read 0, CAP_IRQ=0, and the next capture needs a fresh rise.
6. With SMC_CAP_FILT_EN and FILT_LEN=3, inject a 2-cycle glitch into a 10-high/10-low waveform → PERIOD=20, HIGH=10, no extra capture.
